romload_ctrl: RTL

ROMLOAD_CTRL -- requirements
Module: romload_ctrl

---
 rtl/romload_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/romload_ctrl.sv
// romload_ctrl: HPS ROM download controller with core reset hold-off,
// game-select and DIP bank capture.
// Optional feature: define ROMLOAD_CHECKSUM_EN to add the chk_sum output
// (mod-256 sum of accepted ROM bytes).
module romload_ctrl #(
    parameter int unsigned ROM_SIZE    = 16384,
    parameter int unsigned HOLD_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic [13:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    output logic [1:0]  game_mode,
    output logic [7:0]  dip_sw0,
    output logic        core_reset,
    output logic        rom_loaded,
`ifdef ROMLOAD_CHECKSUM_EN
    output logic [7:0]  chk_sum,
`endif
    output logic        led_busy
);

    localparam int unsigned CNT_W  = $clog2(ROM_SIZE + 1);
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [7:0]  IDX_ROM  = 8'd0;
    localparam logic [7:0]  IDX_GAME = 8'd1;
    localparam logic [7:0]  IDX_DIP  = 8'd254;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic                dl_prev;
    logic [CNT_W-1:0]    byte_cnt, byte_cnt_nx, byte_cnt_acc;
    logic                nz_flag, nz_flag_nx, nz_flag_acc;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
    logic                loaded_nx;

    logic dl_rise, dl_fall, in_range, accept, game_wr, dip_wr;

    // Download edges, write qualification and the post-accept counter/flag view
    always_comb begin
        dl_rise  = ioctl_download & ~dl_prev & (ioctl_index == IDX_ROM);
        dl_fall  = ~ioctl_download & dl_prev;
        in_range = 32'(ioctl_addr) < ROM_SIZE;
        accept   = (state == LOAD) & ioctl_wr & (ioctl_index == IDX_ROM) & in_range;
        game_wr  = ioctl_wr & (ioctl_index == IDX_GAME);
        dip_wr   = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr == 25'd0);

        byte_cnt_acc = byte_cnt;
        if (accept && (byte_cnt != CNT_W'(ROM_SIZE))) begin
            byte_cnt_acc = byte_cnt + CNT_W'(1);
        end
        nz_flag_acc = nz_flag | (accept & (ioctl_dout != 8'd0));
    end

    // Next-state, hold counter, load bookkeeping
    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        byte_cnt_nx = byte_cnt_acc;
        nz_flag_nx  = nz_flag_acc;
        loaded_nx   = rom_loaded;

        if (dl_rise) begin
            state_nx    = LOAD;
            byte_cnt_nx = '0;
            nz_flag_nx  = 1'b0;
            loaded_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                LOAD: begin
                    // A write coinciding with the falling edge is already in the _acc view
                    if (dl_fall) begin
                        if ((byte_cnt_acc != '0) && nz_flag_acc) begin
                            state_nx    = HOLD;
                            hold_cnt_nx = HOLD_W'(HOLD_CYCLES - 1);
                            loaded_nx   = 1'b1;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (user_reset) begin
                        hold_cnt_nx = HOLD_W'(HOLD_CYCLES - 1);
                    end else if (hold_cnt == '0) begin
                        state_nx = RUN;
                    end else begin
                        hold_cnt_nx = hold_cnt - HOLD_W'(1);
                    end
                end
                RUN: begin
                    if (user_reset || game_wr) begin
                        state_nx    = HOLD;
                        hold_cnt_nx = HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // State register with state-derived outputs registered on the same edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= IDLE;
            dl_prev    <= 1'b0;
            byte_cnt   <= '0;
            nz_flag    <= 1'b0;
            hold_cnt   <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
            led_busy   <= 1'b0;
        end else begin
            state      <= state_nx;
            dl_prev    <= ioctl_download;
            byte_cnt   <= byte_cnt_nx;
            nz_flag    <= nz_flag_nx;
            hold_cnt   <= hold_cnt_nx;
            rom_loaded <= loaded_nx;
            core_reset <= (state_nx != RUN);
            led_busy   <= (state_nx == LOAD);
        end
    end

    // ROM write port and configuration registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dn_wr     <= 1'b0;
            dn_addr   <= '0;
            dn_data   <= '0;
            game_mode <= '0;
            dip_sw0   <= '0;
        end else begin
            dn_wr <= accept;
            if (accept) begin
                dn_addr <= ioctl_addr[13:0];
                dn_data <= ioctl_dout;
            end
            if (game_wr) begin
                game_mode <= ioctl_dout[1:0];
            end
            if (dip_wr) begin
                dip_sw0 <= ioctl_dout;
            end
        end
    end

`ifdef ROMLOAD_CHECKSUM_EN
    // Running sum of accepted bytes, restarted on each ROM download
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            chk_sum <= '0;
        end else if (dl_rise) begin
            chk_sum <= '0;
        end else if (accept) begin
            chk_sum <= chk_sum + ioctl_dout;
        end
    end
`endif

endmodule
